config_stream_loader: RTL and testbench
=======================================

Name: config_stream_loader

Overview:
- Parses a byte stream carrying the per-game system configuration, validates it and presents it as registered configuration outputs for the rest of the core.
- Sits between the data-loader byte path and the CPU, screen and input mapping logic.
- Double-buffered: bytes land in shadow registers and commit atomically only after the checksum passes, so a failed or partial load never disturbs the live configuration.

Parameters:
- NUM_S_INPUTS, 8, number of S-line input config words (1..16).
- S_WIDTH, 32, bits per S-line config word (multiple of 8, 8..32).
- CONFIG_VERSION, 8'h01, required version byte.
- MAGIC, 8'h47, required first byte.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begin a new load
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- mpu  out  8  committed MPU select
- screen_config  out  8  committed screen config
- screen_width  out  12  committed width
- screen_height  out  12  committed height
- input_s_config  out  NUM_S_INPUTS*S_WIDTH  committed S configs; word i at [i*S_WIDTH +: S_WIDTH]
- input_b_config  out  8
- input_ba_config  out  8
- input_acl_config  out  8
- grounded_port_config  out  4
- config_valid  out  1  a config has been committed since reset
- busy  out  1  load in progress
- error  out  1  last load failed
- error_code  out  2  0 none, 1 bad magic, 2 bad version, 3 bad checksum

Behaviour:
- Reset (async, active-high): all outputs and shadows 0, state IDLE, in_ready 0, config_valid/busy/error 0, error_code 0.
- Handshake: a byte transfers on a rising edge with in_valid && in_ready. in_ready is a registered decode of state: 1 only in MAGIC, VERSION, PAYLOAD and CSUM.
- Stream order (little-endian multi-byte fields), P = 10 + NUM_S_INPUTS*S_WIDTH/8 payload bytes:
  - magic, version
  - mpu, screen_config
  - width lo, width hi (bits 11:0 kept, hi[7:4] ignored)
  - height lo, height hi (same rule)
  - S words 0..N-1, each S_WIDTH/8 bytes, LSB first
  - b, ba, acl
  - grounded (bits 3:0 kept)
  - checksum byte
- Checksum: 8-bit running sum of every accepted byte from magic through checksum inclusive must equal 8'h00. Sum wraps mod 256.
- States:
  - IDLE: in_ready 0. start -> MAGIC.
  - MAGIC: byte != MAGIC -> ERROR, code 1; else -> VERSION.
  - VERSION: byte != CONFIG_VERSION -> ERROR, code 2; else -> PAYLOAD, byte counter 0.
  - PAYLOAD: each accepted byte written to the shadow field at the counter index, counter +1. Last payload byte (counter == P-1) -> CSUM.
  - CSUM: accept one byte -> CHECK.
  - CHECK: one cycle, in_ready 0. Sum == 0 -> copy all shadows to outputs, config_valid 1, -> IDLE. Else -> ERROR, code 3, outputs untouched.
  - ERROR: in_ready 0, error 1; wait for start.
- Timing: committed outputs change on the edge after the one that accepts the checksum byte; they are visible 2 edges after the checksum handshake.
- busy = 1 in MAGIC through CHECK. start sets busy on the same edge.
- start: accepted in any state, highest priority.
  - Clears error/error_code, running sum, counter and shadows; -> MAGIC.
  - A byte handshake coinciding with start is discarded and not counted.
- config_valid and the committed outputs persist across new loads and failures; only a successful CHECK or reset changes them.
- Bytes presented in IDLE/ERROR are ignored (in_ready 0).
- Stalls (in_valid low) freeze state indefinitely; no timeout.

Test Plan:
- NUM_S_INPUTS=8, S_WIDTH=32:
  - Stream 47,01,02,05,A0,00,90,00, S words 0x11111111..0x88888888, 0C,0D,0E,F3, valid checksum -> after CHECK: mpu=02, screen_config=05, width=0x0A0, height=0x090, word0=0x11111111, word7=0x88888888, grounded=3, config_valid=1, error=0.
  - Same stream with the checksum byte +1 -> error=1, error_code=3, outputs keep prior values, config_valid unchanged.
  - First byte 0x46 -> ERROR after 1 byte, error_code=1, in_ready=0 afterwards.
  - Version 0x02 -> error_code=2.
- Random in_valid gaps (50% duty) on a valid stream -> identical result to the back-to-back case; byte count accepted = 45.
- Assert start mid-PAYLOAD (byte 20) with in_valid high -> that byte dropped, next byte parsed as magic; a full valid stream then commits.
- Assert reset during PAYLOAD -> all outputs 0 immediately (async), in_ready=0, config_valid=0.

Source files
------------

// File: rtl/config_stream_loader.sv
// Configuration stream loader: parses magic/version/payload/checksum into shadow
// bytes and commits them to the live configuration only when the checksum is zero.
module config_stream_loader #(
    parameter int          NUM_S_INPUTS   = 8,
    parameter int          S_WIDTH        = 32,
    parameter logic [7:0]  CONFIG_VERSION = 8'h01,
    parameter logic [7:0]  MAGIC          = 8'h47
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [7:0]                      mpu,
    output logic [7:0]                      screen_config,
    output logic [11:0]                     screen_width,
    output logic [11:0]                     screen_height,
    output logic [NUM_S_INPUTS*S_WIDTH-1:0] input_s_config,
    output logic [7:0]                      input_b_config,
    output logic [7:0]                      input_ba_config,
    output logic [7:0]                      input_acl_config,
    output logic [3:0]                      grounded_port_config,
    output logic                            config_valid,
    output logic                            busy,
    output logic                            error,
    output logic [1:0]                      error_code
);
    localparam int SB = NUM_S_INPUTS * S_WIDTH / 8;
    localparam int P  = 10 + SB;
    localparam int CW = $clog2(P);

    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_VERSION, S_PAYLOAD, S_CSUM, S_CHECK, S_ERROR
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [7:0]          sum_q;
    logic [P-1:0][7:0]   shadow_q;
    logic [P-1:0][7:0]   cfg_q;
    logic                in_ready_q, busy_q, error_q, valid_q;
    logic [1:0]          code_q;
    logic                acc;
    logic [7:0]          sum_d;

    // A byte coinciding with start belongs to the abandoned load and is dropped.
    assign acc   = in_valid && in_ready_q && !start;
    assign sum_d = sum_q + in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            shadow_q   <= '0;
            cfg_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            valid_q    <= 1'b0;
            code_q     <= 2'd0;
        end else if (start) begin
            state_q    <= S_MAGIC;
            cnt_q      <= '0;
            sum_q      <= '0;
            shadow_q   <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            code_q     <= 2'd0;
        end else begin
            case (state_q)
                S_MAGIC: if (acc) begin
                    sum_q <= sum_d;
                    if (in_data != MAGIC) begin
                        state_q    <= S_ERROR;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        code_q     <= 2'd1;
                    end else begin
                        state_q <= S_VERSION;
                    end
                end
                S_VERSION: if (acc) begin
                    sum_q <= sum_d;
                    if (in_data != CONFIG_VERSION) begin
                        state_q    <= S_ERROR;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        code_q     <= 2'd2;
                    end else begin
                        state_q <= S_PAYLOAD;
                        cnt_q   <= '0;
                    end
                end
                S_PAYLOAD: if (acc) begin
                    sum_q           <= sum_d;
                    shadow_q[cnt_q] <= in_data;
                    cnt_q           <= cnt_q + CW'(1);
                    if (cnt_q == CW'(P - 1))
                        state_q <= S_CSUM;
                end
                S_CSUM: if (acc) begin
                    sum_q      <= sum_d;
                    state_q    <= S_CHECK;
                    in_ready_q <= 1'b0;
                end
                S_CHECK: begin
                    busy_q <= 1'b0;
                    if (sum_q == 8'h00) begin
                        cfg_q   <= shadow_q;
                        valid_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        code_q  <= 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload byte layout: mpu, screen, width lo/hi, height lo/hi, S words, b, ba, acl, grounded.
    assign mpu                  = cfg_q[0];
    assign screen_config        = cfg_q[1];
    assign screen_width         = {cfg_q[3][3:0], cfg_q[2]};
    assign screen_height        = {cfg_q[5][3:0], cfg_q[4]};
    assign input_s_config       = cfg_q[6 +: SB];
    assign input_b_config       = cfg_q[6 + SB];
    assign input_ba_config      = cfg_q[7 + SB];
    assign input_acl_config     = cfg_q[8 + SB];
    assign grounded_port_config = cfg_q[9 + SB][3:0];

    logic unused_hi_nibbles;
    assign unused_hi_nibbles = ^{cfg_q[3][7:4], cfg_q[5][7:4], cfg_q[9 + SB][7:4]};

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign error_code   = code_q;
    assign config_valid = valid_q;
endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: configs are generated as fields, serialised to a
// byte stream, driven with optional gaps and compared field-by-field after commit.
module tb_config_stream_loader;
    localparam int N  = 8;
    localparam int SW = 32;

    logic clk = 1'b0, reset, start, in_valid, in_ready;
    logic [7:0] in_data, mpu, screen_config, input_b_config, input_ba_config, input_acl_config;
    logic [11:0] screen_width, screen_height;
    logic [N*SW-1:0] input_s_config;
    logic [3:0] grounded_port_config;
    logic config_valid, busy, error;
    logic [1:0] error_code;

    config_stream_loader #(.NUM_S_INPUTS(N), .S_WIDTH(SW),
                           .CONFIG_VERSION(8'h01), .MAGIC(8'h47)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mpu(mpu), .screen_config(screen_config),
        .screen_width(screen_width), .screen_height(screen_height),
        .input_s_config(input_s_config), .input_b_config(input_b_config),
        .input_ba_config(input_ba_config), .input_acl_config(input_acl_config),
        .grounded_port_config(grounded_port_config), .config_valid(config_valid),
        .busy(busy), .error(error), .error_code(error_code));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mpu, scr, b, ba, acl;
        logic [11:0] w, h;
        logic [N-1:0][SW-1:0] s;
        logic [3:0]  g;
    } cfg_t;

    int errors = 0, checks = 0;
    logic [7:0] stream[$];
    cfg_t cur, live, zero_cfg;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.mpu = 8'($urandom); c.scr = 8'($urandom);
        c.w = 12'($urandom_range(4095)); c.h = 12'($urandom_range(4095));
        for (int i = 0; i < N; i++) c.s[i] = $urandom;
        c.b = 8'($urandom); c.ba = 8'($urandom); c.acl = 8'($urandom);
        c.g = 4'($urandom_range(15));
        return c;
    endfunction

    // Fields -> bytes; ignored high nibbles get junk; checksum makes the total sum zero.
    task automatic build(input cfg_t c, input logic [7:0] mg, input logic [7:0] ver,
                         input logic [7:0] csum_adj);
        logic [7:0] sum;
        stream = {};
        stream.push_back(mg); stream.push_back(ver);
        stream.push_back(c.mpu); stream.push_back(c.scr);
        stream.push_back(c.w[7:0]); stream.push_back({4'($urandom), c.w[11:8]});
        stream.push_back(c.h[7:0]); stream.push_back({4'($urandom), c.h[11:8]});
        for (int i = 0; i < N; i++)
            for (int j = 0; j < SW / 8; j++) stream.push_back(c.s[i][j*8 +: 8]);
        stream.push_back(c.b); stream.push_back(c.ba); stream.push_back(c.acl);
        stream.push_back({4'hF, c.g});
        sum = 8'h00;
        foreach (stream[k]) sum = sum + stream[k];
        stream.push_back(8'h00 - sum + csum_adj);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive stream[0..nmax-1]; each cycle in_valid is low with probability gap%.
    task automatic send(input int gap, input int nmax, output int acc);
        int idx = 0, cyc = 0;
        logic hs;
        acc = 0;
        while (idx < nmax && cyc < 4000) begin
            in_data  = stream[idx];
            in_valid = ($urandom_range(99) >= gap);
            #4;
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin idx++; acc++; end
        end
        in_valid = 1'b0;
        chk("stream_done", 256'(idx), 256'(nmax));
    endtask

    task automatic check_cfg(input string tag, input cfg_t e);
        logic [N*SW-1:0] es;
        for (int i = 0; i < N; i++) es[i*SW +: SW] = e.s[i];
        chk({tag, "_mpu"}, 256'(mpu), 256'(e.mpu));
        chk({tag, "_scr"}, 256'(screen_config), 256'(e.scr));
        chk({tag, "_w"}, 256'(screen_width), 256'(e.w));
        chk({tag, "_h"}, 256'(screen_height), 256'(e.h));
        chk({tag, "_s"}, 256'(input_s_config), 256'(es));
        chk({tag, "_b"}, 256'(input_b_config), 256'(e.b));
        chk({tag, "_ba"}, 256'(input_ba_config), 256'(e.ba));
        chk({tag, "_acl"}, 256'(input_acl_config), 256'(e.acl));
        chk({tag, "_g"}, 256'(grounded_port_config), 256'(e.g));
    endtask

    task automatic check_status(input string tag, input logic v, input logic b,
                                input logic e, input logic [1:0] code, input logic rdy);
        chk({tag, "_valid"}, 256'(config_valid), 256'(v));
        chk({tag, "_busy"}, 256'(busy), 256'(b));
        chk({tag, "_err"}, 256'(error), 256'(e));
        chk({tag, "_code"}, 256'(error_code), 256'(code));
        chk({tag, "_rdy"}, 256'(in_ready), 256'(rdy));
    endtask

    initial begin
        int acc;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        zero_cfg = '{mpu: 8'h0, scr: 8'h0, b: 8'h0, ba: 8'h0, acl: 8'h0,
                     w: 12'h0, h: 12'h0, s: '0, g: 4'h0};
        #16;
        check_cfg("rst", zero_cfg);
        check_status("rst", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed stream from the plan, back to back.
        cur = zero_cfg;
        cur.mpu = 8'h02; cur.scr = 8'h05; cur.w = 12'h0A0; cur.h = 12'h090;
        for (int i = 0; i < N; i++) cur.s[i] = 32'h11111111 * (i + 1);
        cur.b = 8'h0C; cur.ba = 8'h0D; cur.acl = 8'h0E; cur.g = 4'h3;
        build(cur, 8'h47, 8'h01, 8'h00);
        pulse_start();
        check_status("start", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        send(0, stream.size(), acc);
        chk("dir_acc", 256'(acc), 256'(45));
        @(posedge clk); #1;
        live = cur;
        check_cfg("dir", live);
        check_status("dir", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        // Bad checksum: live config untouched.
        build(rand_cfg(), 8'h47, 8'h01, 8'h01);
        pulse_start();
        send(0, stream.size(), acc);
        @(posedge clk); #1;
        check_cfg("badsum", live);
        check_status("badsum", 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);

        // Bad magic: error after one byte, further bytes ignored.
        build(rand_cfg(), 8'h46, 8'h01, 8'h00);
        pulse_start();
        send(0, 1, acc);
        check_status("badmagic", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        in_valid = 1'b1; in_data = 8'h47;
        repeat (3) @(posedge clk);
        #1; in_valid = 1'b0;
        check_status("ignored", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        check_cfg("badmagic", live);

        // Bad version.
        build(rand_cfg(), 8'h47, 8'h02, 8'h00);
        pulse_start();
        send(0, 2, acc);
        check_status("badver", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);

        // Random configs with 50% in_valid gaps.
        for (int r = 0; r < 3; r++) begin
            cur = rand_cfg();
            build(cur, 8'h47, 8'h01, 8'h00);
            pulse_start();
            send(50, stream.size(), acc);
            chk("gap_acc", 256'(acc), 256'(45));
            @(posedge clk); #1;
            live = cur;
            check_cfg("gap", live);
            check_status("gap", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        end

        // Start mid-payload: the coinciding byte is dropped, then a new stream commits.
        build(rand_cfg(), 8'h47, 8'h01, 8'h00);
        pulse_start();
        send(0, 22, acc);
        in_data = stream[22]; in_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        check_status("restart", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        check_cfg("restart", live);
        cur = rand_cfg();
        build(cur, 8'h47, 8'h01, 8'h00);
        send(0, stream.size(), acc);
        @(posedge clk); #1;
        live = cur;
        check_cfg("restart_ok", live);
        check_status("restart_ok", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        // Async reset during payload clears everything without waiting for an edge.
        build(rand_cfg(), 8'h47, 8'h01, 8'h00);
        pulse_start();
        send(0, 12, acc);
        #2 reset = 1'b1;
        #1;
        check_cfg("areset", zero_cfg);
        check_status("areset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
